// File: rtl/aes_fuzz_pkg.sv
// aes_fuzz_pkg: shared FSM type, xorshift64 constants and helpers for the fuzz controller
package aes_fuzz_pkg;

    typedef enum logic [2:0] {IDLE, GEN, TRIGGER, MONITOR, HALT} fuzz_state_t;

    localparam int XS_A = 13;
    localparam int XS_B = 7;
    localparam int XS_C = 17;

    localparam logic [63:0] DEF_SEED = 64'h0123_4567_89AB_CDEF;

    // Trace words are {timeout_flag, key, state, out}; the flag sits at the MSB.
    function automatic int timeout_flag_bit(input int key_w, input int data_w);
        return key_w + 2 * data_w;
    endfunction

    function automatic logic [63:0] xs_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        return y ^ (y << XS_C);
    endfunction

endpackage

// File: rtl/fuzz_trace_buf.sv
// fuzz_trace_buf: circular trace RAM with write pointer, fill level and oldest-relative registered read
module fuzz_trace_buf #(
    parameter int W     = 385,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [W-1:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_phys;
    logic [AW:0]   level_q, level_d;
    logic [W-1:0]  rd_data_q, rd_data_d;

    // Oldest entry lives level slots behind the write pointer; reads past the fill level return 0.
    always_comb begin
        rd_phys   = wr_ptr_q - level_q[AW-1:0] + rd_addr_i;
        wr_ptr_d  = wr_en_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        level_d   = (wr_en_i && level_q != (AW+1)'(DEPTH)) ? level_q + (AW+1)'(1) : level_q;
        rd_data_d = ({1'b0, rd_addr_i} < level_q) ? mem_q[rd_phys] : '0;
    end

    // Storage array carries no reset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointer, level and read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign level_o   = level_q;

endmodule

// File: rtl/aes_fuzz_ctrl_mh.sv
// aes_fuzz_ctrl_mh: xorshift-driven fuzz controller with watchdog, collision history and trace log
module aes_fuzz_ctrl_mh
    import aes_fuzz_pkg::*;
#(
    parameter int          DATA_W      = 128,
    parameter int          KEY_W       = 128,
    parameter int          HIST_DEPTH  = 4,
    parameter int          TRACE_DEPTH = 64,
    parameter logic [63:0] DEF_SEED    = aes_fuzz_pkg::DEF_SEED
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fuzz_en,
    input  logic                                  halt_on_anomaly,
    input  logic                                  seed_load,
    input  logic [63:0]                           seed,
    input  logic [15:0]                           wdog_limit,
    input  logic                                  clear_alarms,
    output logic                                  dut_start,
    output logic [KEY_W-1:0]                      dut_key,
    output logic [DATA_W-1:0]                     dut_state,
    input  logic [DATA_W-1:0]                     dut_out,
    input  logic                                  dut_valid,
    output logic                                  alarm_timeout,
    output logic                                  alarm_collision,
    output logic                                  halted,
    output logic [31:0]                           vec_count,
    output logic [15:0]                           timeout_count,
    output logic [15:0]                           collision_count,
    output logic [KEY_W-1:0]                      err_key,
    output logic [DATA_W-1:0]                     err_state,
    output logic [DATA_W-1:0]                     err_out,
    input  logic [$clog2(TRACE_DEPTH)-1:0]        trace_rd_addr,
    output logic [KEY_W+2*DATA_W:0]               trace_rd_data,
    output logic [$clog2(TRACE_DEPTH):0]          trace_level
);

    localparam int VW  = KEY_W + DATA_W;
    localparam int NW  = VW / 64;
    localparam int GCW = $clog2(NW);
    localparam int TW  = timeout_flag_bit(KEY_W, DATA_W) + 1;
    localparam int HAW = HIST_DEPTH > 1 ? $clog2(HIST_DEPTH) : 1;

    fuzz_state_t       state_q, state_d;
    logic [63:0]       xs_q, xs_d, xs_nxt;
    logic [VW-65:0]    vec_q, vec_d;
    logic [VW-1:0]     vec_nxt;
    logic [GCW-1:0]    gcnt_q, gcnt_d;
    logic [KEY_W-1:0]  key_q, key_d, ekey_q, ekey_d;
    logic [DATA_W-1:0] st_q, st_d, est_q, est_d, eout_q, eout_d, log_out;
    logic [15:0]       timer_q, timer_d, tocnt_q, tocnt_d, cocnt_q, cocnt_d;
    logic [31:0]       vcnt_q, vcnt_d;
    logic              at_q, at_d, ac_q, ac_d;
    logic [KEY_W-1:0]  hkey_q [HIST_DEPTH];
    logic [DATA_W-1:0] hst_q  [HIST_DEPTH];
    logic [DATA_W-1:0] hout_q [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hval_q;
    logic [HAW-1:0]    hptr_q;
    logic              mon, done_ok, tmo, col, collide, anomaly, cap;
    logic [TW-1:0]     trace_wr;

    assign xs_nxt   = xs_step(xs_q);
    assign vec_nxt  = {vec_q, xs_nxt};
    assign mon      = state_q == MONITOR;
    assign done_ok  = mon && dut_valid;
    assign tmo      = mon && !dut_valid && timer_q == wdog_limit;
    assign col      = done_ok && collide;
    assign anomaly  = tmo || col;
    assign cap      = anomaly && !at_q && !ac_q;
    assign log_out  = tmo ? '0 : dut_out;
    assign trace_wr = {tmo, key_q, st_q, log_out};

    // A collision is the same output from a different stimulus anywhere in the valid history.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++)
            collide |= hval_q[i] && hout_q[i] == dut_out && {hkey_q[i], hst_q[i]} != {key_q, st_q};
    end

    // Fuzz loop next-state: seed/launch in IDLE, word assembly in GEN, watchdog in MONITOR.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        vec_d   = vec_q;
        gcnt_d  = gcnt_q;
        key_d   = key_q;
        st_d    = st_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                xs_d    = seed_load ? (seed == '0 ? 64'h1 : seed) : xs_q;
                gcnt_d  = '0;
                state_d = fuzz_en ? GEN : IDLE;
            end
            GEN: begin
                if (!fuzz_en) begin
                    state_d = IDLE;
                    gcnt_d  = '0;
                end else begin
                    xs_d   = xs_nxt;
                    vec_d  = vec_nxt[VW-65:0];
                    gcnt_d = gcnt_q + GCW'(1);
                    if (gcnt_q == GCW'(NW - 1)) begin
                        key_d   = vec_nxt[VW-1:DATA_W];
                        st_d    = vec_nxt[DATA_W-1:0];
                        gcnt_d  = '0;
                        state_d = TRIGGER;
                    end
                end
            end
            TRIGGER: begin
                timer_d = '0;
                state_d = MONITOR;
            end
            MONITOR: begin
                timer_d = timer_q + 16'd1;
                if (done_ok || tmo) state_d = (anomaly && halt_on_anomaly) ? HALT : IDLE;
            end
            HALT:    state_d = clear_alarms ? IDLE : HALT;
            default: state_d = IDLE;
        endcase
    end

    // Sticky alarms, saturating counters and first-anomaly snapshot.
    always_comb begin
        at_d    = (at_q && !clear_alarms) || tmo;
        ac_d    = (ac_q && !clear_alarms) || col;
        vcnt_d  = (done_ok || tmo) ? vcnt_q + 32'd1 : vcnt_q;
        tocnt_d = (tmo && tocnt_q != 16'hFFFF) ? tocnt_q + 16'd1 : tocnt_q;
        cocnt_d = (col && cocnt_q != 16'hFFFF) ? cocnt_q + 16'd1 : cocnt_q;
        ekey_d  = cap ? key_q   : clear_alarms ? '0 : ekey_q;
        est_d   = cap ? st_q    : clear_alarms ? '0 : est_q;
        eout_d  = cap ? log_out : clear_alarms ? '0 : eout_q;
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= DEF_SEED;
            vec_q   <= '0;
            gcnt_q  <= '0;
            key_q   <= '0;
            st_q    <= '0;
            timer_q <= '0;
            at_q    <= 1'b0;
            ac_q    <= 1'b0;
            vcnt_q  <= '0;
            tocnt_q <= '0;
            cocnt_q <= '0;
            ekey_q  <= '0;
            est_q   <= '0;
            eout_q  <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            vec_q   <= vec_d;
            gcnt_q  <= gcnt_d;
            key_q   <= key_d;
            st_q    <= st_d;
            timer_q <= timer_d;
            at_q    <= at_d;
            ac_q    <= ac_d;
            vcnt_q  <= vcnt_d;
            tocnt_q <= tocnt_d;
            cocnt_q <= cocnt_d;
            ekey_q  <= ekey_d;
            est_q   <= est_d;
            eout_q  <= eout_d;
        end
    end

    // History validity and round-robin pointer; only completed (non-timeout) vectors enter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hval_q <= '0;
            hptr_q <= '0;
        end else if (done_ok) begin
            hval_q[hptr_q] <= 1'b1;
            hptr_q         <= (hptr_q == HAW'(HIST_DEPTH - 1)) ? '0 : hptr_q + HAW'(1);
        end
    end

    // History payload; gated by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        if (done_ok) begin
            hkey_q[hptr_q] <= key_q;
            hst_q[hptr_q]  <= st_q;
            hout_q[hptr_q] <= dut_out;
        end
    end

    fuzz_trace_buf #(
        .W     (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (done_ok || tmo),
        .wr_data_i (trace_wr),
        .rd_addr_i (trace_rd_addr),
        .rd_data_o (trace_rd_data),
        .level_o   (trace_level)
    );

    assign dut_start       = state_q == TRIGGER;
    assign halted          = state_q == HALT;
    assign dut_key         = key_q;
    assign dut_state       = st_q;
    assign alarm_timeout   = at_q;
    assign alarm_collision = ac_q;
    assign vec_count       = vcnt_q;
    assign timeout_count   = tocnt_q;
    assign collision_count = cocnt_q;
    assign err_key         = ekey_q;
    assign err_state       = est_q;
    assign err_out         = eout_q;

endmodule
